// File: rtl/bip_pkg.sv
// bip_pkg: shared types for the BIP result transmitter.
// Holds both FSM encodings and the payload byte-count helper.
package bip_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_LOAD,
    SEQ_SEND,
    SEQ_NEXT
  } seq_state_t;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_START,
    SER_DATA,
    SER_STOP
  } ser_state_t;

  // Payload bytes needed to carry an nbits-wide word.
  function automatic int nb_bytes(input int nbits);
    return (nbits + 7) / 8;
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// uart_tx_core: tick-driven UART frame serializer (start/data/stop).
// Ports: i_clk, i_reset, i_tick, i_start, i_din in; o_tx, o_done out.
module uart_tx_core
  import bip_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_tick,
  input  logic       i_start,
  input  logic [7:0] i_din,
  output logic       o_tx,
  output logic       o_done
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

  ser_state_t    state, state_n;
  logic [SW-1:0] s_q, s_n;
  logic [NW-1:0] n_q, n_n;
  logic [7:0]    b_q, b_n;
  logic          tx_q, tx_n;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= SER_IDLE;
      s_q   <= '0;
      n_q   <= '0;
      b_q   <= '0;
      tx_q  <= 1'b1;
    end else begin
      state <= state_n;
      s_q   <= s_n;
      n_q   <= n_n;
      b_q   <= b_n;
      tx_q  <= tx_n;
    end
  end

  always_comb begin
    state_n = state;
    s_n     = s_q;
    n_n     = n_q;
    b_n     = b_q;
    unique case (state)
      SER_IDLE: begin
        if (i_start) begin
          state_n = SER_START;
          s_n     = '0;
          b_n     = i_din;
        end
      end
      SER_START: begin
        if (i_tick) begin
          if (s_q == SW'(15)) begin
            state_n = SER_DATA;
            s_n     = '0;
            n_n     = '0;
          end else begin
            s_n = s_q + 1'b1;
          end
        end
      end
      SER_DATA: begin
        if (i_tick) begin
          if (s_q == SW'(15)) begin
            s_n = '0;
            b_n = {1'b0, b_q[7:1]};
            if (n_q == NW'(DBIT - 1)) begin
              state_n = SER_STOP;
            end else begin
              n_n = n_q + 1'b1;
            end
          end else begin
            s_n = s_q + 1'b1;
          end
        end
      end
      SER_STOP: begin
        if (i_tick) begin
          if (s_q == SW'(SB_TICK - 1)) begin
            state_n = SER_IDLE;
          end else begin
            s_n = s_q + 1'b1;
          end
        end
      end
      default: state_n = SER_IDLE;
    endcase
  end

  // Line level is registered from the next state so it is glitch-free.
  always_comb begin
    unique case (state_n)
      SER_START: tx_n = 1'b0;
      SER_DATA:  tx_n = b_n[0];
      default:   tx_n = 1'b1;
    endcase
    o_done = (state == SER_STOP) && i_tick &&
             (s_q == SW'(SB_TICK - 1));
  end

  assign o_tx = tx_q;

endmodule

// File: rtl/bip_result_tx.sv
// bip_result_tx: sends the BIP result word as optional header + bytes over UART.
// Ports: i_clk, i_reset, i_start, i_data in; o_tx, o_busy, o_done, o_overrun out.
module bip_result_tx
  import bip_pkg::*;
#(
  parameter int         NBITS_D   = 16,
  parameter int         DBIT      = 8,
  parameter int         SB_TICK   = 16,
  parameter int         DIV       = 33,
  parameter bit         MSB_FIRST = 1'b0,
  parameter bit         HEADER_EN = 1'b1,
  parameter logic [7:0] HEADER    = 8'hA5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NBITS_D-1:0] i_data,
  output logic               o_tx,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_overrun
);

  localparam int NB   = nb_bytes(NBITS_D);
  localparam int HB   = HEADER_EN ? 1 : 0;
  localparam int NMSG = NB + HB;
  localparam int WW   = NB * 8;
  localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW   = $clog2(NMSG + 1);

  logic [CW-1:0] div_q;
  logic          tick;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign tick = (div_q == CW'(DIV - 1));

  seq_state_t    state, state_n;
  logic [WW-1:0] word_q, word_n;
  logic [IW-1:0] idx_q, idx_n;
  logic          done_q, done_n;
  logic          accept, more;
  logic          ser_start, ser_done;
  logic [7:0]    byte_cur;
  logic [WW-1:0] word_sh;

  // The busy-fall cycle (done pulse) never accepts a new request.
  assign accept = i_start && !done_q;
  assign more   = (idx_q != IW'(NMSG));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state  <= SEQ_IDLE;
      word_q <= '0;
      idx_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      word_q <= word_n;
      idx_q  <= idx_n;
      done_q <= done_n;
    end
  end

  // idx_q counts bytes already framed; it advances when a frame ends.
  always_comb begin
    state_n = state;
    word_n  = word_q;
    idx_n   = idx_q;
    done_n  = 1'b0;
    unique case (state)
      SEQ_IDLE: begin
        if (accept) begin
          state_n = SEQ_LOAD;
          word_n  = WW'(i_data);
          idx_n   = '0;
        end
      end
      SEQ_LOAD: state_n = SEQ_SEND;
      SEQ_SEND: begin
        if (ser_done) begin
          state_n = SEQ_NEXT;
          idx_n   = idx_q + 1'b1;
        end
      end
      SEQ_NEXT: begin
        if (more) begin
          state_n = SEQ_SEND;
        end else begin
          state_n = SEQ_IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = SEQ_IDLE;
    endcase
  end

  always_comb begin
    ser_start = (state == SEQ_LOAD) ||
                ((state == SEQ_NEXT) && more);
    o_busy    = (state != SEQ_IDLE);
    o_overrun = i_start && o_busy;
  end

  assign o_done = done_q;

  // Byte presented to the serializer for slot idx_q.
  always_comb begin
    int p;
    p = int'(idx_q) - HB;
    if (p < 0 || p >= NB) p = 0;
    if (MSB_FIRST) p = NB - 1 - p;
    word_sh  = word_q >> (p * 8);
    byte_cur = (HEADER_EN && (idx_q == '0)) ? HEADER : word_sh[7:0];
  end

  uart_tx_core #(
    .DBIT    (DBIT),
    .SB_TICK (SB_TICK)
  ) u_core (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_tick  (tick),
    .i_start (ser_start),
    .i_din   (byte_cur),
    .o_tx    (o_tx),
    .o_done  (ser_done)
  );

endmodule

// File: tb/tb_bip_result_tx.sv
// tb_bip_result_tx: directed bench with a UART-receiver model and byte scoreboard.
// Three DUT configurations share one clock and reset.
`timescale 1ns/1ps
module tb_bip_result_tx;

  localparam int DIV = 4;
  localparam int TPF = (1 + 8) * 16 + 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        st0, st1, st2;
  logic [15:0] d0, d1;
  logic [11:0] d2;
  logic tx0, tx1, tx2, bz0, bz1, bz2;
  logic dn0, dn1, dn2, ov0, ov1, ov2;

  bip_result_tx #(.DIV(DIV)) u0 (
    .i_clk(clk), .i_reset(rst), .i_start(st0), .i_data(d0),
    .o_tx(tx0), .o_busy(bz0), .o_done(dn0), .o_overrun(ov0)
  );

  bip_result_tx #(.DIV(DIV), .MSB_FIRST(1'b1), .HEADER_EN(1'b0)) u1 (
    .i_clk(clk), .i_reset(rst), .i_start(st1), .i_data(d1),
    .o_tx(tx1), .o_busy(bz1), .o_done(dn1), .o_overrun(ov1)
  );

  bip_result_tx #(.NBITS_D(12), .DIV(DIV), .HEADER_EN(1'b0)) u2 (
    .i_clk(clk), .i_reset(rst), .i_start(st2), .i_data(d2),
    .o_tx(tx2), .o_busy(bz2), .o_done(dn2), .o_overrun(ov2)
  );

  int sel;
  logic tx_m, bz_m, dn_m, ov_m, st_m;

  always_comb begin
    tx_m = tx0; bz_m = bz0; dn_m = dn0; ov_m = ov0; st_m = st0;
    if (sel == 1) begin
      tx_m = tx1; bz_m = bz1; dn_m = dn1; ov_m = ov1; st_m = st1;
    end else if (sel == 2) begin
      tx_m = tx2; bz_m = bz2; dn_m = dn2; ov_m = ov2; st_m = st2;
    end
  end

  int n_chk, n_fail, n_done, n_ovr;
  logic [7:0] exp_q[$];
  logic [7:0] rx_log[$];
  bit         rx_on;
  int         rx_cnt;
  logic [7:0] rx_sh;
  int         busy_cnt;
  logic       prev_dn;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act,
                         input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Message model: optional header, then zero-extended payload bytes.
  task automatic push_msg(input logic [63:0] d, input int nbits,
                          input bit msb, input bit hdr);
    int nb;
    logic [63:0] v;
    nb = (nbits + 7) / 8;
    v = d;
    if (nbits < 64) v = d & ((64'd1 << nbits) - 64'd1);
    if (hdr) exp_q.push_back(8'hA5);
    for (int p = 0; p < nb; p++) begin
      int k;
      k = msb ? (nb - 1 - p) : p;
      exp_q.push_back(v[8*k +: 8]);
    end
  endtask

  function automatic int msg_len(input int s);
    return (s == 0) ? 3 : 2;
  endfunction

  // Per-cycle check plus a mid-bit sampling UART receiver.
  task automatic compare_cycle();
    int m;
    if (rst) begin
      rx_on = 0; busy_cnt = 0; prev_dn = 1'b0;
      return;
    end
    chk("overrun_rule", ov_m, st_m & bz_m);
    if (!bz_m) chk("idle_line", tx_m, 1);
    if (ov_m) n_ovr++;
    if (bz_m) busy_cnt++;
    if (dn_m) begin
      n_done++;
      m = msg_len(sel);
      chk("done_busy_low", bz_m, 0);
      chk("done_width", prev_dn, 0);
      chk("done_all_bytes", exp_q.size(), 0);
      chk_rng("msg_cycles", busy_cnt, m * TPF * DIV - DIV,
              m * TPF * DIV + 2 * m);
      busy_cnt = 0;
    end
    prev_dn = dn_m;
    if (!rx_on) begin
      if (tx_m == 1'b0) begin
        rx_on = 1; rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % (16 * DIV) == 8 * DIV) begin
        m = rx_cnt / (16 * DIV);
        if (m == 0) begin
          chk("start_bit", tx_m, 0);
        end else if (m <= 8) begin
          rx_sh = {tx_m, rx_sh[7:1]};
        end else begin
          chk("stop_bit", tx_m, 1);
          rx_on = 0;
          rx_log.push_back(rx_sh);
          if (exp_q.size() == 0) chk("rx_unexpected", 0, 1);
          else chk("rx_byte", rx_sh, exp_q.pop_front());
        end
      end
    end
  endtask

  task automatic wait_done(input string nm, input int lim);
    bit seen;
    seen = 0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clk);
      if (dn_m) seen = 1;
    end
    chk(nm, seen, 1);
  endtask

  task automatic chk_log(input string nm, input int n,
                         input logic [47:0] e);
    chk({nm, "_len"}, rx_log.size(), n);
    for (int i = 0; i < n && i < rx_log.size(); i++)
      chk(nm, rx_log[i], e[8*i +: 8]);
  endtask

  task automatic pulse(input int s);
    @(posedge clk); #1;
    if (s == 0) st0 = 1; else if (s == 1) st1 = 1; else st2 = 1;
    @(posedge clk); #1;
    st0 = 0; st1 = 0; st2 = 0;
  endtask

  initial begin
    int nov, nd;
    n_chk = 0; n_fail = 0; n_done = 0; n_ovr = 0;
    rx_on = 0; rx_cnt = 0; rx_sh = '0; busy_cnt = 0; prev_dn = 0;
    sel = 0; rst = 1;
    st0 = 0; st1 = 0; st2 = 0;
    d0 = '0; d1 = '0; d2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", tx0, 1);
    chk("rst_busy", bz0, 0);
    chk("rst_done", dn0, 0);
    chk("rst_ovr", ov0, 0);
    chk("rst_tx1", tx1, 1);
    chk("rst_tx2", tx2, 1);
    rst = 0;
    fork
      forever begin
        @(negedge clk);
        compare_cycle();
      end
    join_none

    // Defaults: header then LSB-first payload.
    sel = 0; rx_log.delete(); nov = n_ovr; nd = n_done;
    d0 = 16'h1234; push_msg(64'h1234, 16, 0, 1);
    pulse(0);
    wait_done("t1_done", 4000);
    repeat (3) @(posedge clk);
    chk_log("t1_bytes", 3, 48'h0000_0012_34A5);
    chk("t1_ndone", n_done - nd, 1);
    chk("t1_novr", n_ovr - nov, 0);

    // Most significant byte first, no header.
    sel = 1; rx_log.delete();
    d1 = 16'h1234; push_msg(64'h1234, 16, 1, 0);
    pulse(1);
    wait_done("t2_done", 4000);
    repeat (3) @(posedge clk);
    chk_log("t2_bytes", 2, 48'h0000_0000_3412);

    // 12-bit word: upper nibble of the second byte is zero.
    sel = 2; rx_log.delete();
    d2 = 12'hABC; push_msg(64'hABC, 12, 0, 0);
    pulse(2);
    wait_done("t3_done", 4000);
    repeat (3) @(posedge clk);
    chk_log("t3_bytes", 2, 48'h0000_0000_0ABC);

    // Second request during the payload is flagged and ignored.
    sel = 0; rx_log.delete(); nov = n_ovr;
    d0 = 16'h00FF; push_msg(64'h00FF, 16, 0, 1);
    pulse(0);
    repeat (1000) @(posedge clk);
    #1; d0 = 16'h7777; st0 = 1;
    @(posedge clk); #1; st0 = 0;
    wait_done("t4_done", 4000);
    repeat (3) @(posedge clk);
    chk("t4_novr", n_ovr - nov, 1);
    chk_log("t4_bytes", 3, 48'h0000_0000_FFA5);

    // Reset while the second frame is in its data bits.
    rx_log.delete(); nd = n_done;
    d0 = 16'h1234; push_msg(64'h1234, 16, 0, 1);
    pulse(0);
    repeat (900) @(posedge clk);
    chk("t5_busy_pre", bz0, 1);
    #2; rst = 1;
    #1;
    chk("t5_rst_tx", tx0, 1);
    chk("t5_rst_busy", bz0, 0);
    repeat (2) @(posedge clk);
    exp_q.delete(); rx_log.delete();
    #1; rst = 0;
    repeat (20) @(posedge clk);
    chk("t5_no_done", n_done - nd, 0);
    d0 = 16'h5A5A; push_msg(64'h5A5A, 16, 0, 1);
    pulse(0);
    wait_done("t5_done", 4000);
    repeat (3) @(posedge clk);
    chk_log("t5_bytes", 3, 48'h0000_005A_5AA5);

    // Held request: back-to-back messages with one re-arm gap.
    rx_log.delete(); nov = n_ovr;
    d0 = 16'hBEEF; push_msg(64'hBEEF, 16, 0, 1);
    @(posedge clk); #1; st0 = 1;
    wait_done("t6_done1", 4000);
    @(posedge clk); #1;
    push_msg(64'hBEEF, 16, 0, 1);
    @(negedge clk);
    chk("t6_gap_idle", bz0, 0);
    @(negedge clk);
    chk("t6_rearm", bz0, 1);
    wait_done("t6_done2", 4000);
    st0 = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("t6_stopped", bz0, 0);
    chk("t6_many_ovr", (n_ovr - nov) > 1000, 1);
    chk_log("t6_bytes", 6, 48'hBEEF_A5BE_EFA5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
